// File: rtl/spi_pkg.sv
// Shared types for the SPI master sequencer: FSM state encoding and FIFO counter sizing.
package spi_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_START     = 3'd1,
        SEQ_WAIT_BUSY = 3'd2,
        SEQ_WAIT_DONE = 3'd3,
        SEQ_CAPTURE   = 3'd4
    } seq_state_t;

    // Counter must hold 0..depth inclusive, hence one bit beyond the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_master_sequencer_if.sv
// Bundles the system-side FIFO handshakes and the SPI master driver handshake.
// master modport is the sequencer's view; slave modport is the surrounding system/driver.
interface spi_master_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  busy;
    logic                  timeout_err;
    logic                  err_clear;
    logic                  start_transaction;
    logic [DATA_WIDTH-1:0] master_data_in;
    logic [DATA_WIDTH-1:0] master_data_out;
    logic                  master_ready;

    modport master (
        input  tx_data, tx_valid, rx_ready, err_clear, master_data_out, master_ready,
        output tx_ready, rx_data, rx_valid, busy, timeout_err, start_transaction, master_data_in
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, err_clear, master_data_out, master_ready,
        input  tx_ready, rx_data, rx_valid, busy, timeout_err, start_transaction, master_data_in
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head; head reads as zero when empty.
// Zero-latency head; pushes while full and pops while empty are ignored.
module spi_sync_fifo
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_master_sequencer.sv
// Buffers TX words and issues one SPI master transaction per word, queueing replies in RX.
// Start pulse two cycles after a push into an idle sequencer; stalls when RX is full.
module spi_master_sequencer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_master_sequencer_if.master bus
);
    localparam int TW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

    seq_state_t            state, state_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  timeout_err;

    logic                  tx_full, tx_empty, tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  rx_full, rx_empty, rx_push;
    logic                  timeout_hit;

    spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.tx_valid && !tx_full),
        .push_data (bus.tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (bus.master_data_out),
        .pop       (bus.rx_ready),
        .head      (bus.rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            SEQ_IDLE: begin
                // Waiting on RX room here is what makes the CAPTURE push overflow-free.
                if (!tx_empty && !rx_full && bus.master_ready) begin
                    tx_pop    = 1'b1;
                    state_nxt = SEQ_START;
                end
            end
            SEQ_START: begin
                timer_nxt = '0;
                state_nxt = SEQ_WAIT_BUSY;
            end
            SEQ_WAIT_BUSY: begin
                if (!bus.master_ready) begin
                    state_nxt = SEQ_WAIT_DONE;
                end else if (timer == TW'(START_TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = SEQ_IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            SEQ_WAIT_DONE: begin
                if (bus.master_ready) state_nxt = SEQ_CAPTURE;
            end
            SEQ_CAPTURE: begin
                rx_push   = 1'b1;
                state_nxt = SEQ_IDLE;
            end
            default: state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SEQ_IDLE;
            timer       <= '0;
            data_reg    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (tx_pop) data_reg <= tx_head;
            if (timeout_hit)        timeout_err <= 1'b1;
            else if (bus.err_clear) timeout_err <= 1'b0;
        end
    end

    assign bus.tx_ready          = !tx_full;
    assign bus.rx_valid          = !rx_empty;
    assign bus.busy              = (state != SEQ_IDLE) || !tx_empty;
    assign bus.timeout_err       = timeout_err;
    assign bus.start_transaction = (state == SEQ_START);
    assign bus.master_data_in    = data_reg;

endmodule
